// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU.
// Holds decoded operands and control for one cycle, resolves EX-stage
// forwarding from MEM and WB, and inserts a bubble on a load-use hazard.
module id_ex_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [3:0]            id_alu_func,
  input  logic [1:0]            id_srca_sel,
  input  logic [1:0]            id_srcb_sel,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  mem_fwd_valid,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [XLEN-1:0]       alu_srca,
  output logic [XLEN-1:0]       alu_srcb,
  output logic [3:0]            alu_func,
  output logic [XLEN-1:0]       ex_store_data
);

  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [1:0]            r_srca_sel;
  logic [1:0]            r_srcb_sel;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;
  logic                  hazard;
  logic                  clear;
  logic                  load;

  // Load-use hazard: EX holds a load whose destination the ID instruction reads.
  always_comb begin
    hazard = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid &&
             ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
              (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    load_use_stall = hazard && !flush;
  end

  // Edge action: rst > flush > stall hold > load bubble > capture.
  // An invalid ID slot is captured as a bubble so no stray control leaks into EX.
  always_comb begin
    clear = rst || flush || (!stall && (load_use_stall || !id_valid));
    load  = !clear && !stall;
  end

  // Group-wise register update; fields never change independently.
  always_ff @(posedge clk) begin
    if (clear) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      alu_func     <= 4'b0000;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_srca_sel   <= 2'b00;
      r_srcb_sel   <= 2'b00;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_rd_addr   <= id_rd_addr;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      alu_func     <= id_alu_func;
      r_rs1_data   <= id_rs1_data;
      r_rs2_data   <= id_rs2_data;
      r_imm        <= id_imm;
      r_rs1_addr   <= id_rs1_addr;
      r_rs2_addr   <= id_rs2_addr;
      r_srca_sel   <= id_srca_sel;
      r_srcb_sel   <= id_srcb_sel;
    end
  end

  // Forwarding: MEM is younger than WB so it wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = r_rs1_data;
    fwd_rs2 = r_rs2_data;
    if (ex_valid && (r_rs1_addr != '0)) begin
      if (mem_fwd_valid && (mem_fwd_rd == r_rs1_addr))     fwd_rs1 = mem_fwd_data;
      else if (wb_fwd_valid && (wb_fwd_rd == r_rs1_addr))  fwd_rs1 = wb_fwd_data;
    end
    if (ex_valid && (r_rs2_addr != '0)) begin
      if (mem_fwd_valid && (mem_fwd_rd == r_rs2_addr))     fwd_rs2 = mem_fwd_data;
      else if (wb_fwd_valid && (wb_fwd_rd == r_rs2_addr))  fwd_rs2 = wb_fwd_data;
    end
  end

  // Operand muxing; a bubble presents zero operands to the ALU.
  always_comb begin
    alu_srca      = '0;
    alu_srcb      = '0;
    ex_store_data = fwd_rs2;
    if (ex_valid) begin
      case (r_srca_sel)
        2'b00:   alu_srca = fwd_rs1;
        2'b01:   alu_srca = ex_pc;
        default: alu_srca = '0;
      endcase
      case (r_srcb_sel)
        2'b00:   alu_srcb = fwd_rs2;
        2'b01:   alu_srcb = r_imm;
        2'b10:   alu_srcb = XLEN'(4);
        default: alu_srcb = '0;
      endcase
    end
  end

endmodule
